ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain loader for the eFPGA fabric. It accepts bitstream words over a valid/ready stream and shifts them serially into the fabric configuration chain (`ccff_head` → … → `ccff_tail`) on `prog_clk`. It also captures the bits falling out of `ccff_tail` and returns them as a readback word stream. It sits between the host programming interface and the first tile's `ccff_head`, and gates chain advance through a clock-enable.

## Interface
- `WORD_W`, default 32 — bitstream word width, ≥2.
- `CHAIN_LEN`, default 4096 — total configuration bits in the chain, ≥1.
- `prog_clk`  in  1  — programming clock; all state is on the rising edge.
- `prog_reset_n`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — one-cycle pulse that begins a load. Ignored unless the block is IDLE.
- `s_valid`  in  1  — bitstream word valid.
- `s_ready`  out  1  — loader can accept a word.
- `s_data`  in  WORD_W  — bitstream word. Bit 0 is shifted first.
- `m_valid`  out  1  — readback word valid.
- `m_ready`  in  1  — readback sink ready.
- `m_data`  out  WORD_W  — readback word. Bit i is the i-th bit captured within that word.
- `ccff_head`  out  1  — serial data to the chain.
- `ccff_shift_en`  out  1  — chain advances at the next `prog_clk` edge. The integrator uses it to drive the chain ICG enable.
- `ccff_tail`  in  1  — serial data from the chain end.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse when the final readback word is accepted.

## Operation

**States:** IDLE, FETCH, SHIFT, PUSH. State encoding is a shared enum.

- **IDLE**
  - `start` → FETCH.
  - `total_cnt` clears to 0.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid`&`s_ready`: load the word into the shift register, clear `bit_idx`, go to SHIFT.
  - No word present → hold; `ccff_shift_en`=0.
- **SHIFT**
  - Each cycle: `ccff_shift_en`=1 and `ccff_head`=`word[bit_idx]`.
  - At the same edge, capture `ccff_tail` into `rb[bit_idx]`, then increment `bit_idx` and `total_cnt`.
  - Leave SHIFT when `bit_idx`==WORD_W−1 or `total_cnt`==CHAIN_LEN−1; the bit in that cycle is still shifted. Next state is PUSH.
- **PUSH**
  - `m_valid`=1 and `m_data`=`rb`. Uncaptured positions of a partial final word are 0.
  - On `m_ready`: if `total_cnt`==CHAIN_LEN, pulse `done` and go to IDLE; otherwise go to FETCH.
  - `m_valid` stays high with `m_data` stable until accepted.

**Counters and widths**
- `total_cnt` is $clog2(CHAIN_LEN+1) bits and never exceeds CHAIN_LEN.
- `bit_idx` is $clog2(WORD_W) bits.

**Final and last words**
- Final word is partial when CHAIN_LEN mod WORD_W ≠ 0. Only the low (CHAIN_LEN mod WORD_W) bits are shifted; upper bits are discarded.
- The host supplies exactly ceil(CHAIN_LEN/WORD_W) words. Words after the last one are not consumed (`s_ready`=0 in IDLE).

**Boundary conditions**
- `start` while busy: ignored, no effect on counters.
- `s_valid` dropping mid-load: stalls in FETCH, chain frozen, no bit lost or duplicated.
- `m_ready` low: stalls in PUSH, chain frozen.
- Reset asserted mid-load: immediately returns to IDLE with all outputs at reset values; chain contents are undefined.
- CHAIN_LEN < WORD_W: a single partial word, then `done`.

**Reset values:** `s_ready`=0, `m_valid`=0, `m_data`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0; state IDLE; counters 0.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from `s_valid`, `m_ready` or `ccff_tail` to any output.
- Start to ready: `start` at edge 0 → `s_ready`=1 in cycle 1.
- Word accept to first shift: word accepted at edge k → `ccff_shift_en`=1 in cycle k+1.
- A full word occupies WORD_W consecutive shift cycles.
- Minimum per full word: WORD_W+2 cycles (FETCH, WORD_W×SHIFT, PUSH), assuming zero-wait source and sink.
- `ccff_head` and `ccff_shift_en` change only on `prog_clk` rising edges and are valid for the whole cycle.
- `ccff_tail` is sampled at the edge where the chain shifts, i.e. the bit leaving the chain.
- Readback word n carries the chain's previous contents, bits n·WORD_W … n·WORD_W+WORD_W−1 counted from the tail.

## Structure
- **Package `ccff_loader_pkg`:** the state enum `ccff_state_t`.
- **Sub-module `ccff_word_serdes`:** the PISO/SIPO pair with `bit_idx`. It holds the load word, drives the head bit, and captures tail bits into `rb`.
- **Top level:** FSM, `total_cnt`, handshakes.

## Test plan
1. **Partial last word.** WORD_W=8, CHAIN_LEN=10. Bench models a 10-bit chain preloaded with 0x3FF. Send words 0xA5, 0x02.
   - Chain = host bits in order.
   - Readback 0xFF, 0x03.
   - `done` pulses once.
   - Exactly 10 `ccff_shift_en` cycles.
2. **Source stall.** Same configuration; `s_valid` held low 5 cycles between words → `ccff_shift_en`=0 throughout the gap; final chain identical to scenario 1.
3. **Sink stall.** `m_ready` low 7 cycles at the first PUSH → `m_valid` stays high, `m_data`=0xFF stable, no shifts, no `s_ready`.
4. **Start while busy.** Assert `start` during SHIFT → ignored; total shift count stays 10; a single `done`.
5. **Reset mid-load.** Assert `prog_reset_n`=0 after 3 shifts → all outputs 0 in the same cycle. A new load after release completes correctly.
6. **Single full word.** CHAIN_LEN=8, WORD_W=8, word 0x81 → 8 shifts, one readback word, `done` 10 cycles after word accept with zero-wait sink.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PUSH  = 2'd3
  } ccff_state_t;

endpackage

// File: rtl/ccff_word_serdes.sv
// Word-wide PISO toward ccff_head and SIPO from ccff_tail, sharing one bit index.
module ccff_word_serdes #(
  parameter int WORD_W = 32,
  localparam int IDX_W = $clog2(WORD_W)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_word,
  input  logic              tail_bit,
  output logic              head_bit,
  output logic              last_bit,
  output logic [WORD_W-1:0] rb
);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  bit_idx;

  // Loading clears rb so the unshifted positions of a partial word read back as 0.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      word_q  <= '0;
      rb      <= '0;
      bit_idx <= '0;
    end else if (load) begin
      word_q  <= load_word;
      rb      <= '0;
      bit_idx <= '0;
    end else if (shift) begin
      rb[bit_idx] <= tail_bit;
      bit_idx     <= bit_idx + IDX_W'(1);
    end
  end

  assign head_bit = word_q[bit_idx];
  assign last_bit = (bit_idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words serially into the fabric config chain and returns the bits shifted out.
//
// state  | meaning
// IDLE   | waiting for start, total_cnt held at 0
// FETCH  | s_ready high, waiting for the next bitstream word
// SHIFT  | one chain bit per cycle, tail bit captured into the readback word
// PUSH   | readback word offered on m_valid/m_data until accepted
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 4096
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  ccff_state_t       state_q, state_d;
  logic [CNT_W-1:0]  total_cnt;
  logic              done_q;
  logic              load;
  logic              shift;
  logic              head_bit;
  logic              last_bit;
  logic [WORD_W-1:0] rb;
  logic              chain_last;
  logic              chain_full;

  assign chain_last = (total_cnt == CNT_W'(CHAIN_LEN - 1));
  assign chain_full = (total_cnt == CNT_W'(CHAIN_LEN));

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (s_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (last_bit || chain_last) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (m_ready) state_d = chain_full ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      total_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      total_cnt <= '0;
    end else if (shift) begin
      total_cnt <= total_cnt + CNT_W'(1);
    end
  end

  // done is registered so m_ready has no combinational path to an output.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_PUSH) && m_ready && chain_full;
    end
  end

  ccff_word_serdes #(
    .WORD_W (WORD_W)
  ) u_serdes (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .load         (load),
    .shift        (shift),
    .load_word    (s_data),
    .tail_bit     (ccff_tail),
    .head_bit     (head_bit),
    .last_bit     (last_bit),
    .rb           (rb)
  );

  assign s_ready       = (state_q == ST_FETCH);
  assign m_valid       = (state_q == ST_PUSH);
  assign m_data        = rb;
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign ccff_head     = ccff_shift_en & head_bit;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (10-bit and 8-bit chains, 8-bit words) with chain models.
module tb_ccff_loader;

  localparam int W = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic           rst_n    [2];
  logic           start    [2];
  logic           s_valid  [2];
  logic           s_ready  [2];
  logic [W-1:0]   s_data   [2];
  logic           m_valid  [2];
  logic           m_ready  [2];
  logic [W-1:0]   m_data   [2];
  logic           head     [2];
  logic           shift_en [2];
  logic           tail     [2];
  logic           busy     [2];
  logic           done     [2];

  logic [15:0]    chain    [2];
  logic           pre_ld   [2];
  logic [15:0]    pre_val  [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int shift_cnt[2];
  int done_cnt [2];
  int rb_n     [2];
  int done_cyc [2];
  int acc_cyc  [2];
  logic [W-1:0] rb_mem[2][8];

  ccff_loader #(.WORD_W(W), .CHAIN_LEN(10)) u_dut_a (
    .prog_clk      (prog_clk),
    .prog_reset_n  (rst_n[0]),
    .start         (start[0]),
    .s_valid       (s_valid[0]),
    .s_ready       (s_ready[0]),
    .s_data        (s_data[0]),
    .m_valid       (m_valid[0]),
    .m_ready       (m_ready[0]),
    .m_data        (m_data[0]),
    .ccff_head     (head[0]),
    .ccff_shift_en (shift_en[0]),
    .ccff_tail     (tail[0]),
    .busy          (busy[0]),
    .done          (done[0])
  );

  ccff_loader #(.WORD_W(W), .CHAIN_LEN(8)) u_dut_b (
    .prog_clk      (prog_clk),
    .prog_reset_n  (rst_n[1]),
    .start         (start[1]),
    .s_valid       (s_valid[1]),
    .s_ready       (s_ready[1]),
    .s_data        (s_data[1]),
    .m_valid       (m_valid[1]),
    .m_ready       (m_ready[1]),
    .m_data        (m_data[1]),
    .ccff_head     (head[1]),
    .ccff_shift_en (shift_en[1]),
    .ccff_tail     (tail[1]),
    .busy          (busy[1]),
    .done          (done[1])
  );

  // Chain models: bit 0 sits next to ccff_head, bit len-1 drives ccff_tail.
  assign tail[0] = chain[0][9];
  assign tail[1] = chain[1][7];

  initial begin
    chain[0] = '0;
    chain[1] = '0;
    for (int d = 0; d < 2; d++) begin
      shift_cnt[d] = 0;
      done_cnt[d]  = 0;
      rb_n[d]      = 0;
      done_cyc[d]  = 0;
      acc_cyc[d]   = 0;
    end
  end

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (pre_ld[d]) chain[d] <= pre_val[d];
      else if (shift_en[d]) chain[d] <= {chain[d][14:0], head[d]};
    end
  end

  always @(negedge prog_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (shift_en[d]) shift_cnt[d] <= shift_cnt[d] + 1;
      if (m_valid[d] && m_ready[d]) begin
        rb_mem[d][rb_n[d] % 8] <= m_data[d];
        rb_n[d] <= rb_n[d] + 1;
      end
      if (done[d]) begin
        done_cnt[d] <= done_cnt[d] + 1;
        done_cyc[d] <= cyc;
      end
      if (s_valid[d] && s_ready[d]) acc_cyc[d] <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic int len_of(input int d);
    return (d == 0) ? 10 : 8;
  endfunction

  // Readback word n, bit i = chain bit (n*W+i) counted from the tail.
  function automatic logic [W-1:0] exp_rb(input int len, input logic [15:0] pre, input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      int j = n * W + i;
      if (j < len) r[i] = pre[len - 1 - j];
    end
    return r;
  endfunction

  // After a load, host bit j sits j positions from the tail.
  function automatic logic [15:0] exp_chain(input int len, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [15:0] c = '0;
    for (int j = 0; j < len; j++) c[len - 1 - j] = (j < W) ? w0[j] : w1[j - W];
    return c;
  endfunction

  task automatic check_idle_outputs(input int d, input string tag);
    check_eq(tag, {24'h0, s_ready[d], m_valid[d], head[d], shift_en[d], busy[d], done[d], 2'b00},
             32'h0);
    check_eq({tag, "_mdata"}, {24'h0, m_data[d]}, 32'h0);
  endtask

  task automatic run_load(input int d, input logic [15:0] pre, input logic [W-1:0] w0,
                          input logic [W-1:0] w1, input int gap, input int sink_hold,
                          input bit mid_start, input string tag);
    int len;
    int nw;
    int sc0;
    int dc0;
    int rn0;
    int t;
    bit gap_ok;
    bit hold_ok;
    logic [W-1:0] w[2];
    logic [15:0] mask;
    len  = len_of(d);
    nw   = (len + W - 1) / W;
    w[0] = w0;
    w[1] = w1;
    mask = (16'h1 << len) - 16'h1;
    pre_val[d] = pre;
    pre_ld[d]  = 1'b1;
    tick();
    pre_ld[d]  = 1'b0;
    sc0 = shift_cnt[d];
    dc0 = done_cnt[d];
    rn0 = rb_n[d];
    m_ready[d] = (sink_hold == 0);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check_eq({tag, "_start_ready"}, {31'h0, s_ready[d]}, 32'h1);
    for (int wi = 0; wi < nw; wi++) begin
      t = 0;
      while (!s_ready[d] && t < 100) begin
        tick();
        t++;
      end
      check_eq({tag, "_fetch"}, {31'h0, s_ready[d]}, 32'h1);
      if (wi > 0 && gap > 0) begin
        gap_ok = 1'b1;
        for (int g = 0; g < gap; g++) begin
          if (shift_en[d] || !s_ready[d]) gap_ok = 1'b0;
          tick();
        end
        check_eq({tag, "_gap_frozen"}, {31'h0, gap_ok}, 32'h1);
      end
      s_valid[d] = 1'b1;
      s_data[d]  = w[wi];
      tick();
      s_valid[d] = 1'b0;
      s_data[d]  = $urandom();
      check_eq({tag, "_first_shift"}, {31'h0, shift_en[d]}, 32'h1);
      if (wi == 0 && mid_start) begin
        tick();
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
      end
      if (wi == 0 && sink_hold > 0) begin
        t = 0;
        while (!m_valid[d] && t < 50) begin
          tick();
          t++;
        end
        hold_ok = 1'b1;
        for (int h = 0; h < sink_hold; h++) begin
          if (!m_valid[d] || m_data[d] !== exp_rb(len, pre, 0) || shift_en[d] || s_ready[d])
            hold_ok = 1'b0;
          tick();
        end
        check_eq({tag, "_sink_hold"}, {31'h0, hold_ok}, 32'h1);
        m_ready[d] = 1'b1;
      end
    end
    t = 0;
    while (done_cnt[d] == dc0 && t < 300) begin
      tick();
      t++;
    end
    tick();
    tick();
    tick();
    check_eq({tag, "_done_cnt"}, 32'(done_cnt[d] - dc0), 32'h1);
    check_eq({tag, "_shifts"}, 32'(shift_cnt[d] - sc0), 32'(len));
    check_eq({tag, "_rb_words"}, 32'(rb_n[d] - rn0), 32'(nw));
    for (int n = 0; n < nw; n++)
      check_eq({tag, "_rb_data"}, {24'h0, rb_mem[d][(rn0 + n) % 8]}, {24'h0, exp_rb(len, pre, n)});
    check_eq({tag, "_chain"}, {16'h0, chain[d] & mask}, {16'h0, exp_chain(len, w0, w1)});
    check_eq({tag, "_idle"}, {31'h0, busy[d]}, 32'h0);
    if (nw == 1 && sink_hold == 0)
      check_eq({tag, "_done_lat"}, 32'(done_cyc[d] - acc_cyc[d]), 32'd10);
  endtask

  task automatic reset_mid_load(input int d);
    int sc0;
    int t;
    pre_val[d] = 16'($urandom());
    pre_ld[d]  = 1'b1;
    tick();
    pre_ld[d]  = 1'b0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    s_valid[d] = 1'b1;
    s_data[d]  = 8'($urandom());
    tick();
    s_valid[d] = 1'b0;
    sc0 = shift_cnt[d];
    t = 0;
    while (shift_cnt[d] - sc0 < 3 && t < 50) begin
      tick();
      t++;
    end
    check_eq("t5_pre_reset_busy", {31'h0, busy[d]}, 32'h1);
    rst_n[d] = 1'b0;
    #1;
    check_idle_outputs(d, "t5_reset_outs");
    tick();
    tick();
    rst_n[d] = 1'b1;
    tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]   = 1'b0;
      start[d]   = 1'b0;
      s_valid[d] = 1'b0;
      s_data[d]  = '0;
      m_ready[d] = 1'b1;
      pre_ld[d]  = 1'b0;
      pre_val[d] = '0;
    end
    tick();
    tick();
    check_idle_outputs(0, "reset_a");
    check_idle_outputs(1, "reset_b");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();

    run_load(0, 16'h03FF, 8'hA5, 8'h02, 0, 0, 1'b0, "t1");
    run_load(0, 16'h03FF, 8'hA5, 8'h02, 5, 0, 1'b0, "t2");
    run_load(0, 16'h03FF, 8'hA5, 8'h02, 0, 7, 1'b0, "t3");
    run_load(0, 16'($urandom()), 8'h3C, 8'h01, 0, 0, 1'b1, "t4");
    reset_mid_load(0);
    run_load(0, 16'($urandom()), 8'($urandom()), 8'($urandom()), 0, 0, 1'b0, "t5_after");
    run_load(1, 16'($urandom()), 8'h81, 8'h00, 0, 0, 1'b0, "t6");

    for (int k = 0; k < 8; k++) begin
      run_load(int'($urandom_range(0, 1)), 16'($urandom()), 8'($urandom()), 8'($urandom()),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
